// File: rtl/me_frame_scheduler.sv
// Frame-level scheduler for the hexagon motion-estimation engine: walks every
// 16x16 macroblock in raster order, hands each to the engine and records its result.
module me_frame_scheduler #(
  parameter int unsigned WIDTH  = 352,
  parameter int unsigned HEIGHT = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [31:0]       frame_addr_in,
  output logic              me_start,
  output logic [31:0]       me_frame_addr,
  output logic [31:0]       me_mb_x,
  output logic [31:0]       me_mb_y,
  input  logic              me_done,
  input  logic signed [5:0] me_mv_x,
  input  logic signed [5:0] me_mv_y,
  input  logic [15:0]       me_sad,
  output logic              res_we,
  output logic [8:0]        res_addr,
  output logic [31:0]       res_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [24:0]       frame_sad
);

  localparam int unsigned COLS = WIDTH / 16;
  localparam int unsigned ROWS = HEIGHT / 16;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_accept;
  logic          w_capture;
  logic          w_step;
  logic          w_launch;
  logic          w_finish;
  logic          w_last;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [8:0]    r_idx;
  logic          r_adv;
  logic          r_me_start;
  logic [31:0]   r_frame_addr;
  logic          r_res_we;
  logic [8:0]    r_res_addr;
  logic [31:0]   r_res_wdata;
  logic          r_busy;
  logic          r_frame_done;
  logic [24:0]   r_frame_sad;

  assign w_last = (r_col == LAST_COL) && (r_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // RELEASE takes two steps between macroblocks: the position advances once
  // me_done is seen low, and me_start rises only on the following edge, so the
  // engine never sees a position change coincide with its start.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_step       = 1'b0;
    w_launch     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (me_done) begin
          w_capture    = 1'b1;
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (r_adv) begin
          w_launch     = 1'b1;
          w_state_next = ISSUE;
        end else if (!me_done) begin
          if (w_last) begin
            w_finish     = 1'b1;
            w_state_next = DONE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_idx        <= '0;
      r_adv        <= 1'b0;
      r_me_start   <= 1'b0;
      r_frame_addr <= '0;
      r_res_we     <= 1'b0;
      r_res_addr   <= '0;
      r_res_wdata  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_sad  <= '0;
    end else begin
      r_res_we     <= w_capture;
      r_frame_done <= w_finish;
      if (w_accept) begin
        r_frame_addr <= frame_addr_in;
        r_col        <= '0;
        r_row        <= '0;
        r_idx        <= '0;
        r_adv        <= 1'b0;
        r_frame_sad  <= '0;
        r_busy       <= 1'b1;
        r_me_start   <= 1'b1;
      end
      if (w_capture) begin
        r_res_addr  <= r_idx;
        r_res_wdata <= {4'b0000, me_mv_x, me_mv_y, me_sad};
        r_frame_sad <= r_frame_sad + 25'(me_sad);
        r_me_start  <= 1'b0;
      end
      if (w_step) begin
        r_adv <= 1'b1;
        r_idx <= r_idx + 9'd1;
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_launch) begin
        r_adv      <= 1'b0;
        r_me_start <= 1'b1;
      end
      if (w_finish) r_busy <= 1'b0;
      // Park on macroblock 0 so the next frame's first position is settled early.
      if (r_state == DONE) begin
        r_col <= '0;
        r_row <= '0;
        r_idx <= '0;
      end
    end
  end

  assign me_start      = r_me_start;
  assign me_frame_addr = r_frame_addr;
  assign me_mb_x       = {28'(r_col), 4'b0000};
  assign me_mb_y       = {28'(r_row), 4'b0000};
  assign res_we        = r_res_we;
  assign res_addr      = r_res_addr;
  assign res_wdata     = r_res_wdata;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign frame_sad     = r_frame_sad;

endmodule
